// File: rtl/hack_pkg.sv
// Shared Hack memory-map constants and address decode, used by the CPU, memory and top level.
package hack_pkg;

    localparam int          RAM_SIZE         = 16384;
    localparam int          SCREEN_SIZE      = 8192;
    localparam logic [15:0] SCREEN_BASE      = 16'h4000;
    localparam logic [15:0] KBD_ADDR_DEFAULT = 16'h6000;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_SCREEN,
        REGION_KBD,
        REGION_NONE
    } region_e;

    function automatic region_e decode_region(input logic [15:0] addr,
                                              input int          ram_words,
                                              input int          screen_words,
                                              input logic [15:0] kbd_addr);
        int a;
        int scr_lo;
        a      = int'(addr);
        scr_lo = int'(SCREEN_BASE);
        if (a < ram_words)
            return REGION_RAM;
        else if (a >= scr_lo && a < scr_lo + screen_words)
            return REGION_SCREEN;
        else if (addr == kbd_addr)
            return REGION_KBD;
        else
            return REGION_NONE;
    endfunction

endpackage

// File: rtl/hack_ram_dp.sv
// Screen frame buffer: async-read/sync-write CPU port plus a registered video read port.
module hack_ram_dp #(
    parameter int DEPTH  = 8192,
    parameter int AW     = 13,
    parameter int VID_AW = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [15:0]       cpu_wdata,
    input  logic              cpu_we,
    output logic [15:0]       cpu_rdata,
    input  logic              vid_req,
    input  logic [VID_AW-1:0] vid_addr,
    output logic [15:0]       vid_data,
    output logic              vid_valid
);

    logic [15:0] mem [DEPTH];
    logic        vid_hit_p0;
    logic [15:0] vid_data_p1;
    logic        vld_p1;

    assign cpu_rdata  = mem[cpu_addr];
    assign vid_hit_p0 = 32'(vid_addr) < 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (cpu_we)
            mem[cpu_addr] <= cpu_wdata;
    end

    // p0 -> p1: video read samples the array before this edge's CPU write lands
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            vid_data_p1 <= '0;
        end else begin
            vld_p1      <= vid_req;
            vid_data_p1 <= vid_hit_p0 ? mem[vid_addr[AW-1:0]] : '0;
        end
    end

    assign vid_data  = vid_data_p1;
    assign vid_valid = vld_p1;

endmodule

// File: rtl/hack_memory.sv
// Hack data memory: RAM, screen frame buffer and keyboard register behind one CPU port.
module hack_memory
    import hack_pkg::*;
#(
    parameter int          RAM_WORDS    = RAM_SIZE,
    parameter int          SCREEN_WORDS = SCREEN_SIZE,
    parameter logic [15:0] KBD_ADDR     = KBD_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    input  logic        kbd_release,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    input  logic        vid_frame_start,
    output logic        screen_dirty
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);

    region_e           region;
    logic [15:0]       ram [RAM_WORDS];
    logic [15:0]       kbd_reg;
    logic [15:0]       scr_rdata;
    logic [SCR_AW-1:0] scr_off;
    logic              ram_we;
    logic              scr_we;
    logic              dirty;

    assign region  = decode_region(addressM, RAM_WORDS, SCREEN_WORDS, KBD_ADDR);
    assign scr_off = SCR_AW'(addressM - SCREEN_BASE);
    assign ram_we  = writeM && (region == REGION_RAM);
    assign scr_we  = writeM && (region == REGION_SCREEN);

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[addressM[RAM_AW-1:0]] <= outM;
    end

    hack_ram_dp #(
        .DEPTH  (SCREEN_WORDS),
        .AW     (SCR_AW),
        .VID_AW (13)
    ) u_screen (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (scr_off),
        .cpu_wdata (outM),
        .cpu_we    (scr_we),
        .cpu_rdata (scr_rdata),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid)
    );

    always_comb begin
        inM = 16'h0000;
        case (region)
            REGION_RAM:    inM = ram[addressM[RAM_AW-1:0]];
            REGION_SCREEN: inM = scr_rdata;
            REGION_KBD:    inM = kbd_reg;
            default:       inM = 16'h0000;
        endcase
    end

    // A press in the same cycle as a release wins, so fast typing never loses a key.
    always_ff @(posedge clk) begin
        if (reset)
            kbd_reg <= '0;
        else if (kbd_valid)
            kbd_reg <= kbd_code;
        else if (kbd_release)
            kbd_reg <= '0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            dirty <= 1'b0;
        else if (scr_we)
            dirty <= 1'b1;
        else if (vid_frame_start)
            dirty <= 1'b0;
    end

    assign screen_dirty = dirty;

endmodule

// File: tb/tb_hack_memory.sv
// Self-checking bench for hack_memory: directed scenarios plus randomized traffic against a memory-map model.
module tb_hack_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        kbd_release;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic [15:0] vid_data;
    logic        vid_valid;
    logic        vid_frame_start;
    logic        screen_dirty;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [15:0] ram_m [16384];
    logic [15:0] scr_m [8192];
    bit          scr_known [8192];
    logic [15:0] kbd_m;
    logic        dirty_m;
    logic        vv_m;
    logic [15:0] vd_m;
    bit          vk_m;

    hack_memory dut (
        .clk             (clk),
        .reset           (reset),
        .addressM        (addressM),
        .outM            (outM),
        .writeM          (writeM),
        .inM             (inM),
        .kbd_valid       (kbd_valid),
        .kbd_code        (kbd_code),
        .kbd_release     (kbd_release),
        .vid_req         (vid_req),
        .vid_addr        (vid_addr),
        .vid_data        (vid_data),
        .vid_valid       (vid_valid),
        .vid_frame_start (vid_frame_start),
        .screen_dirty    (screen_dirty)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_inm(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'h4000;
        if (a < 16'h4000)      return ram_m[a[13:0]];
        else if (a < 16'h6000) return scr_m[off[12:0]];
        else if (a == 16'h6000) return kbd_m;
        else                   return 16'h0000;
    endfunction

    task automatic idle();
        reset = 0; addressM = 0; outM = 0; writeM = 0;
        kbd_valid = 0; kbd_code = 0; kbd_release = 0;
        vid_req = 0; vid_addr = 0; vid_frame_start = 0;
    endtask

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        logic [15:0] a;
        logic [15:0] off;
        bit          scr_wr;
        a      = addressM;
        off    = a - 16'h4000;
        scr_wr = writeM && a >= 16'h4000 && a < 16'h6000;
        if (reset) begin
            vv_m = 0; vd_m = 0; vk_m = 1;
        end else begin
            vv_m = vid_req; vd_m = scr_m[vid_addr]; vk_m = scr_known[vid_addr];
        end
        if (writeM && a < 16'h4000) ram_m[a[13:0]] = outM;
        if (scr_wr) begin
            scr_m[off[12:0]] = outM;
            scr_known[off[12:0]] = 1;
        end
        if (reset)            kbd_m = 0;
        else if (kbd_valid)   kbd_m = kbd_code;
        else if (kbd_release) kbd_m = 0;
        if (reset)                dirty_m = 0;
        else if (scr_wr)          dirty_m = 1;
        else if (vid_frame_start) dirty_m = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [15:0] a, input logic [15:0] d);
        idle(); addressM = a; outM = d; writeM = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle(); reset = 1;
        tick(); tick();
        idle(); addressM = 16'h6000; #1;
        n_checks++; if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vid_valid got %h want 0", vid_valid); end
        n_checks++; if (vid_data !== 16'h0) begin n_fail++; $display("FAIL reset_vid_data got %h want 0000", vid_data); end
        n_checks++; if (screen_dirty !== 1'b0) begin n_fail++; $display("FAIL reset_dirty got %h want 0", screen_dirty); end
        n_checks++; if (inM !== 16'h0) begin n_fail++; $display("FAIL reset_kbd got %h want 0000", inM); end
    endtask

    task automatic test_ram();
        write(16'h0005, 16'd21);
        addressM = 16'h0005; #1;
        n_checks++; if (inM !== 16'h0015) begin n_fail++; $display("FAIL ram_read got %h want 0015", inM); end
        addressM = 16'h7000; #1;
        n_checks++; if (inM !== 16'h0000) begin n_fail++; $display("FAIL unmapped_7000 got %h want 0000", inM); end
        addressM = 16'h6001; #1;
        n_checks++; if (inM !== 16'h0000) begin n_fail++; $display("FAIL unmapped_6001 got %h want 0000", inM); end
        write(16'h3FFF, 16'hBEEF);
        addressM = 16'h3FFF; #1;
        n_checks++; if (inM !== 16'hBEEF) begin n_fail++; $display("FAIL ram_top got %h want beef", inM); end
    endtask

    task automatic test_screen_video();
        write(16'h4000, 16'd21);
        vid_req = 1; vid_addr = 0;
        n_checks++; if (screen_dirty !== 1'b1) begin n_fail++; $display("FAIL dirty_after_write got %h want 1", screen_dirty); end
        tick();
        idle();
        n_checks++; if (vid_valid !== 1'b1) begin n_fail++; $display("FAIL vid_valid got %h want 1", vid_valid); end
        n_checks++; if (vid_data !== 16'h0015) begin n_fail++; $display("FAIL vid_data got %h want 0015", vid_data); end
        tick();
        n_checks++; if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL vid_valid_drop got %h want 0", vid_valid); end
        write(16'h5FFF, 16'hC0DE);
        addressM = 16'h5FFF; #1;
        n_checks++; if (inM !== 16'hC0DE) begin n_fail++; $display("FAIL screen_top_cpu got %h want c0de", inM); end
        vid_req = 1; vid_addr = 13'h1FFF;
        tick(); idle();
        n_checks++; if (vid_data !== 16'hC0DE) begin n_fail++; $display("FAIL screen_top_vid got %h want c0de", vid_data); end
    endtask

    task automatic test_kbd();
        idle(); kbd_valid = 1; kbd_code = 16'h0041;
        tick(); idle(); addressM = 16'h6000; #1;
        n_checks++; if (inM !== 16'h0041) begin n_fail++; $display("FAIL kbd_press got %h want 0041", inM); end
        kbd_release = 1;
        tick(); idle(); addressM = 16'h6000; #1;
        n_checks++; if (inM !== 16'h0000) begin n_fail++; $display("FAIL kbd_release got %h want 0000", inM); end
        kbd_valid = 1; kbd_release = 1; kbd_code = 16'h0080;
        tick(); idle(); addressM = 16'h6000; #1;
        n_checks++; if (inM !== 16'h0080) begin n_fail++; $display("FAIL kbd_both got %h want 0080", inM); end
    endtask

    task automatic test_dirty();
        idle(); vid_frame_start = 1;
        tick(); idle();
        n_checks++; if (screen_dirty !== 1'b0) begin n_fail++; $display("FAIL dirty_clear got %h want 0", screen_dirty); end
        addressM = 16'h4010; outM = 16'h1111; writeM = 1; vid_frame_start = 1;
        tick(); idle();
        n_checks++; if (screen_dirty !== 1'b1) begin n_fail++; $display("FAIL dirty_write_and_frame got %h want 1", screen_dirty); end
        vid_frame_start = 1;
        tick(); idle();
        n_checks++; if (screen_dirty !== 1'b0) begin n_fail++; $display("FAIL dirty_next_frame got %h want 0", screen_dirty); end
    endtask

    task automatic test_read_before_write();
        write(16'h4003, 16'hAAAA);
        addressM = 16'h4003; outM = 16'h5555; writeM = 1; vid_req = 1; vid_addr = 13'd3; #1;
        n_checks++; if (inM !== 16'hAAAA) begin n_fail++; $display("FAIL rbw_screen_cpu got %h want aaaa", inM); end
        tick(); idle();
        n_checks++; if (vid_data !== 16'hAAAA) begin n_fail++; $display("FAIL rbw_screen_vid got %h want aaaa", vid_data); end
        addressM = 16'h4003; #1;
        n_checks++; if (inM !== 16'h5555) begin n_fail++; $display("FAIL rbw_screen_after got %h want 5555", inM); end
        write(16'h0006, 16'h0101);
        addressM = 16'h0006; outM = 16'h0202; writeM = 1; #1;
        n_checks++; if (inM !== 16'h0101) begin n_fail++; $display("FAIL rbw_ram got %h want 0101", inM); end
        tick(); idle();
    endtask

    task automatic test_kbd_write_and_reset_burst();
        idle(); kbd_valid = 1; kbd_code = 16'h0033;
        tick();
        write(16'h6000, 16'h1234);
        addressM = 16'h6000; #1;
        n_checks++; if (inM !== 16'h0033) begin n_fail++; $display("FAIL kbd_write_ignored got %h want 0033", inM); end
        for (int i = 0; i < 4; i++) begin
            idle(); vid_req = 1; vid_addr = 13'(i);
            tick();
            n_checks++; if (vid_valid !== 1'b1) begin n_fail++; $display("FAIL burst_valid[%0d] got %h want 1", i, vid_valid); end
        end
        idle(); reset = 1; vid_req = 1; addressM = 16'h0007; outM = 16'h7777; writeM = 1;
        tick();
        n_checks++; if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_burst_valid got %h want 0", vid_valid); end
        idle();
        tick();
        n_checks++; if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_discarded got %h want 0", vid_valid); end
        addressM = 16'h0005; #1;
        n_checks++; if (inM !== 16'h0015) begin n_fail++; $display("FAIL ram_kept_over_reset got %h want 0015", inM); end
        addressM = 16'h0007; #1;
        n_checks++; if (inM !== 16'h7777) begin n_fail++; $display("FAIL write_during_reset got %h want 7777", inM); end
        addressM = 16'h6000; #1;
        n_checks++; if (inM !== 16'h0000) begin n_fail++; $display("FAIL kbd_cleared_by_reset got %h want 0000", inM); end
    endtask

    task automatic test_random();
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) begin
            write(16'(i), 16'($urandom));
            write(16'h4000 + 16'(i), 16'($urandom));
        end
        for (int c = 0; c < 400; c++) begin
            idle();
            case ($urandom_range(0, 3))
                0: addressM = 16'($urandom_range(0, 15));
                1: addressM = 16'h4000 + 16'($urandom_range(0, 15));
                2: addressM = 16'h6000;
                default: addressM = 16'($urandom_range(16'h6001, 16'hFFFF));
            endcase
            writeM          = ($urandom_range(0, 2) == 0);
            outM            = 16'($urandom);
            kbd_valid       = ($urandom_range(0, 5) == 0);
            kbd_release     = ($urandom_range(0, 5) == 0);
            kbd_code        = 16'($urandom);
            vid_req         = ($urandom_range(0, 1) == 1);
            vid_addr        = 13'($urandom_range(0, 15));
            vid_frame_start = ($urandom_range(0, 7) == 0);
            #1;
            exp = exp_inm(addressM);
            n_checks++; if (inM !== exp) begin n_fail++; $display("FAIL rand_inM[%0d] addr %h got %h want %h", c, addressM, inM, exp); end
            tick();
            n_checks++; if (vid_valid !== vv_m) begin n_fail++; $display("FAIL rand_vid_valid[%0d] got %h want %h", c, vid_valid, vv_m); end
            if (vv_m && vk_m) begin
                n_checks++; if (vid_data !== vd_m) begin n_fail++; $display("FAIL rand_vid_data[%0d] got %h want %h", c, vid_data, vd_m); end
            end
            n_checks++; if (screen_dirty !== dirty_m) begin n_fail++; $display("FAIL rand_dirty[%0d] got %h want %h", c, screen_dirty, dirty_m); end
        end
        idle();
    endtask

    initial begin
        kbd_m = 0; dirty_m = 0; vv_m = 0; vd_m = 0; vk_m = 1;
        idle();
        @(negedge clk);
        test_reset();
        test_ram();
        test_screen_video();
        test_kbd();
        test_dirty();
        test_read_before_write();
        test_kbd_write_and_reset_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
